multichannel_fifobram: RTL and testbench
========================================

# multichannel_fifobram

Multi-channel FIFO built on one shared simple-dual-port BRAM: NUM_CHANNELS independent circular queues, each 2**LOG2_DEPTH words deep, with one write port and one read port selectable per cycle by channel index. It generalises the single-queue fifobram_interface fifo_source behaviour (we/wdata, re/rdata/rvalid, almostfull/empty/count) to per-channel status, adds full flags, per-channel flush, and sticky overflow/underflow error flags. It sits between the memory-read engines and the compute pipelines, so multiple prefetch streams can share one BRAM.

## Interface
- WIDTH, 32, data word width
- LOG2_DEPTH, 9, log2 of per-channel depth
- NUM_CHANNELS, 4, number of queues (power of two)
- LOG2_CHANNELS, 2, log2(NUM_CHANNELS)
- ALMOSTFULL_MARGIN, 16, almostfull asserts when free slots <= margin; must be < 2**LOG2_DEPTH
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- we  in  1  write request
- wchannel  in  LOG2_CHANNELS  target channel of write
- wdata  in  WIDTH  write data
- re  in  1  read request
- rchannel  in  LOG2_CHANNELS  source channel of read
- clear  in  NUM_CHANNELS  per-channel flush, one bit per channel
- rdata  out  WIDTH  read data, registered
- rvalid  out  1  rdata valid
- rvalid_channel  out  LOG2_CHANNELS  channel rdata came from
- count  out  NUM_CHANNELS*(LOG2_DEPTH+1)  per-channel occupancy, channel c at bits [c*(LOG2_DEPTH+1) +: LOG2_DEPTH+1]
- empty  out  NUM_CHANNELS  count==0
- full  out  NUM_CHANNELS  count==2**LOG2_DEPTH
- almostfull  out  NUM_CHANNELS  count >= 2**LOG2_DEPTH - ALMOSTFULL_MARGIN
- overflow  out  NUM_CHANNELS  sticky: write rejected because full
- underflow  out  NUM_CHANNELS  sticky: read rejected because empty

## Operation
- Storage: NUM_CHANNELS*2**LOG2_DEPTH words; physical address {channel, ptr}. Per channel: LOG2_DEPTH-bit wptr and rptr, LOG2_DEPTH+1-bit count.
- Pointers wrap modulo 2**LOG2_DEPTH; no gap word, full distinguished by count.
- Acceptance uses pre-edge state only: write accepted iff we && !full[wchannel] && !clear[wchannel]; read accepted iff re && !empty[rchannel] && !clear[rchannel].
- Accepted write: mem[{wchannel,wptr}] <= wdata, wptr+1, count+1.
- Accepted read: rptr+1, count-1; data appears on rdata next cycle.
- Same channel, accepted write and read in one cycle: both pointers advance, count unchanged.
- Write to full channel: dropped, overflow[wchannel] <= 1. Read from empty channel: dropped, underflow[rchannel] <= 1. Read of empty channel concurrent with write to it is rejected (no fall-through).
- clear[c]: next edge wptr=rptr=0, count=0, overflow[c]=underflow[c]=0; overrides any we/re to c that cycle (silently dropped, no error flag). Other channels unaffected.
- empty/full/almostfull are combinational decodes of registered count; no extra latency.
- Overflow/underflow cleared only by reset or clear[c].

## Timing
- Reset (resetn low, async): rdata=0, rvalid=0, rvalid_channel=0, count=0, empty=all 1, full=0, almostfull=0, overflow=0, underflow=0, all pointers 0. Memory contents not reset. Any in-flight read is discarded; no rvalid after release.
- Read latency 1: accepted re at edge k -> rvalid=1, rdata, rvalid_channel valid for cycle after edge k, rvalid low otherwise.
- Write at edge k visible in status after edge k; a read of that channel in the following cycle is accepted and returns that data.
- Read accepted at edge k, clear at edge k+1: rvalid for the read still fires.
- Throughput: one write and one read per cycle, any channel mix.

## Test plan
- LOG2_DEPTH=4, MARGIN=4: write 0x100..0x10F to ch2 -> count[2] 1..16, almostfull[2] from count 12, full[2] at 16; 17th write -> overflow[2]=1, count stays 16.
- Read ch2 16 times back-to-back -> rdata 0x100..0x10F in order, rvalid each cycle after re, rvalid_channel=2; extra read -> no rvalid, underflow[2]=1.
- Interleave writes ch0/ch1 (A0,B0,A1,B1) then reads ch1,ch0,ch1,ch0 -> B0,A0,B1,A1; counts independent.
- Ch3 at count 5, simultaneous write and read each cycle for 40 cycles -> count stays 5, data order preserved across 2+ pointer wraps.
- Ch1 holding 8 words with overflow[1]=1, assert clear[1] with we to ch1 -> count[1]=0, empty[1]=1, overflow[1]=0, write dropped; ch0 contents unchanged.
- resetn low mid-stream with read in flight -> all outputs to reset values immediately, no rvalid after release, empty=all 1.

Source files
------------

// File: rtl/multichannel_fifobram.sv
// Multi-channel FIFO: NUM_CHANNELS circular queues sharing one simple-dual-port RAM.
// One write and one read per cycle, each steered by channel index; registered read data.
module multichannel_fifobram #(
    parameter int WIDTH             = 32,
    parameter int LOG2_DEPTH        = 9,
    parameter int NUM_CHANNELS      = 4,
    parameter int LOG2_CHANNELS     = 2,
    parameter int ALMOSTFULL_MARGIN = 16
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   we,
    input  logic [LOG2_CHANNELS-1:0]               wchannel,
    input  logic [WIDTH-1:0]                       wdata,
    input  logic                                   re,
    input  logic [LOG2_CHANNELS-1:0]               rchannel,
    input  logic [NUM_CHANNELS-1:0]                clear,
    output logic [WIDTH-1:0]                       rdata,
    output logic                                   rvalid,
    output logic [LOG2_CHANNELS-1:0]               rvalid_channel,
    output logic [NUM_CHANNELS*(LOG2_DEPTH+1)-1:0] count,
    output logic [NUM_CHANNELS-1:0]                empty,
    output logic [NUM_CHANNELS-1:0]                full,
    output logic [NUM_CHANNELS-1:0]                almostfull,
    output logic [NUM_CHANNELS-1:0]                overflow,
    output logic [NUM_CHANNELS-1:0]                underflow
);

    localparam int PW        = LOG2_DEPTH;
    localparam int CW        = LOG2_DEPTH + 1;
    localparam int AW        = LOG2_CHANNELS + LOG2_DEPTH;
    localparam int MEM_WORDS = NUM_CHANNELS << LOG2_DEPTH;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(1 << LOG2_DEPTH);
    localparam logic [CW-1:0] AF_THRESH = CW'((1 << LOG2_DEPTH) - ALMOSTFULL_MARGIN);

    logic [WIDTH-1:0] mem [MEM_WORDS];

    logic [PW-1:0] wptr_q  [NUM_CHANNELS];
    logic [PW-1:0] wptr_d  [NUM_CHANNELS];
    logic [PW-1:0] rptr_q  [NUM_CHANNELS];
    logic [PW-1:0] rptr_d  [NUM_CHANNELS];
    logic [CW-1:0] count_q [NUM_CHANNELS];
    logic [CW-1:0] count_d [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]  overflow_q, overflow_d;
    logic [NUM_CHANNELS-1:0]  underflow_q, underflow_d;
    logic                     rvalid_q, rvalid_d;
    logic [LOG2_CHANNELS-1:0] rvalid_channel_q, rvalid_channel_d;
    logic [WIDTH-1:0]         rdata_q;

    logic                    wr_ok, rd_ok;
    logic [NUM_CHANNELS-1:0] wr_hit, rd_hit, wr_blocked, rd_blocked;
    logic [AW-1:0]           waddr, raddr;

    // Status flags decode the registered occupancy directly.
    always_comb begin
        count      = '0;
        empty      = '0;
        full       = '0;
        almostfull = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            count[c*CW +: CW] = count_q[c];
            empty[c]          = (count_q[c] == '0);
            full[c]           = (count_q[c] == DEPTH_CNT);
            almostfull[c]     = (count_q[c] >= AF_THRESH);
        end
    end

    // Acceptance looks only at pre-edge state; a clear on the target channel wins.
    always_comb begin
        wr_ok = we && !full[wchannel] && !clear[wchannel];
        rd_ok = re && !empty[rchannel] && !clear[rchannel];
        waddr = {wchannel, wptr_q[wchannel]};
        raddr = {rchannel, rptr_q[rchannel]};
        wr_hit     = '0;
        rd_hit     = '0;
        wr_blocked = '0;
        rd_blocked = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            wr_hit[c]     = wr_ok && (wchannel == LOG2_CHANNELS'(c));
            rd_hit[c]     = rd_ok && (rchannel == LOG2_CHANNELS'(c));
            wr_blocked[c] = we && (wchannel == LOG2_CHANNELS'(c)) && full[c];
            rd_blocked[c] = re && (rchannel == LOG2_CHANNELS'(c)) && empty[c];
        end
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (clear[c]) begin
                wptr_d[c]      = '0;
                rptr_d[c]      = '0;
                count_d[c]     = '0;
                overflow_d[c]  = 1'b0;
                underflow_d[c] = 1'b0;
            end else begin
                if (wr_hit[c]) wptr_d[c] = wptr_q[c] + PW'(1);
                if (rd_hit[c]) rptr_d[c] = rptr_q[c] + PW'(1);
                unique case ({wr_hit[c], rd_hit[c]})
                    2'b10:   count_d[c] = count_q[c] + CW'(1);
                    2'b01:   count_d[c] = count_q[c] - CW'(1);
                    default: count_d[c] = count_q[c];
                endcase
                if (wr_blocked[c]) overflow_d[c]  = 1'b1;
                if (rd_blocked[c]) underflow_d[c] = 1'b1;
            end
        end
        rvalid_d         = rd_ok;
        rvalid_channel_d = rd_ok ? rchannel : rvalid_channel_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
                count_q[c] <= '0;
            end
            overflow_q       <= '0;
            underflow_q      <= '0;
            rvalid_q         <= 1'b0;
            rvalid_channel_q <= '0;
        end else begin
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            underflow_q      <= underflow_d;
            rvalid_q         <= rvalid_d;
            rvalid_channel_q <= rvalid_channel_d;
        end
    end

    // Storage is not reset so it can map onto block RAM. A write and a read can
    // never hit the same word: a non-full, non-empty channel has wptr != rptr.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem[raddr];
    end

    assign rdata          = rdata_q;
    assign rvalid         = rvalid_q;
    assign rvalid_channel = rvalid_channel_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_multichannel_fifobram.sv
// Directed bench for multichannel_fifobram (depth 16, margin 4, 4 channels).
// Reads push {channel, data} into a queue; a negedge monitor pops on every rvalid.
module tb_multichannel_fifobram;

    localparam int W  = 32;
    localparam int LD = 4;
    localparam int NC = 4;
    localparam int LC = 2;
    localparam int CW = LD + 1;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            we = 1'b0;
    logic [LC-1:0]   wchannel = '0;
    logic [W-1:0]    wdata = '0;
    logic            re = 1'b0;
    logic [LC-1:0]   rchannel = '0;
    logic [NC-1:0]   clear = '0;
    logic [W-1:0]    rdata;
    logic            rvalid;
    logic [LC-1:0]   rvalid_channel;
    logic [NC*CW-1:0] count;
    logic [NC-1:0]   empty, full, almostfull, overflow, underflow;

    logic [LC+W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    multichannel_fifobram #(
        .WIDTH(W), .LOG2_DEPTH(LD), .NUM_CHANNELS(NC),
        .LOG2_CHANNELS(LC), .ALMOSTFULL_MARGIN(4)
    ) dut (
        .clk(clk), .resetn(resetn), .we(we), .wchannel(wchannel), .wdata(wdata),
        .re(re), .rchannel(rchannel), .clear(clear), .rdata(rdata), .rvalid(rvalid),
        .rvalid_channel(rvalid_channel), .count(count), .empty(empty), .full(full),
        .almostfull(almostfull), .overflow(overflow), .underflow(underflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int c);
        return count[c*CW +: CW];
    endfunction

    // Read latency is exactly one cycle, so every non-empty queue slot must meet rvalid.
    always @(negedge clk) begin
        if (resetn) begin
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 64'(rvalid), 64'(0));
                end else begin
                    logic [LC+W-1:0] e;
                    e = exp_q.pop_front();
                    check("rdata", 64'(rdata), 64'(e[W-1:0]));
                    check("rvalid_channel", 64'(rvalid_channel), 64'(e[LC+W-1:W]));
                end
            end else if (exp_q.size() != 0) begin
                check("missing_rvalid", 64'(rvalid), 64'(1));
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic w, input logic [LC-1:0] wc, input logic [W-1:0] wd,
                         input logic r, input logic [LC-1:0] rc, input logic [NC-1:0] clr,
                         input logic push_exp, input logic [W-1:0] exp_d);
        we = w; wchannel = wc; wdata = wd;
        re = r; rchannel = rc; clear = clr;
        @(posedge clk);
        if (push_exp) exp_q.push_back({rc, exp_d});
        #1;
        we = 1'b0; re = 1'b0; clear = '0;
    endtask

    task automatic wr(input logic [LC-1:0] c, input logic [W-1:0] d);
        drive(1'b1, c, d, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic rd(input logic [LC-1:0] c, input logic [W-1:0] d);
        drive(1'b0, '0, '0, 1'b1, c, '0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rvalid"}, 64'(rvalid), 64'(0));
        check({tag, "_rdata"}, 64'(rdata), 64'(0));
        check({tag, "_rvalid_channel"}, 64'(rvalid_channel), 64'(0));
        check({tag, "_count"}, 64'(count), 64'(0));
        check({tag, "_empty"}, 64'(empty), 64'(4'hF));
        check({tag, "_full"}, 64'(full), 64'(0));
        check({tag, "_almostfull"}, 64'(almostfull), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
        check({tag, "_underflow"}, 64'(underflow), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        resetn = 1'b1;
        idle(1);

        // Fill channel 2 to full, then one write too many.
        for (int i = 0; i < 16; i++) begin
            wr(2'd2, 32'h100 + 32'(i));
            check("fill_count2", 64'(cnt(2)), 64'(i + 1));
            check("fill_almostfull2", 64'(almostfull[2]), 64'((i + 1) >= 12));
            check("fill_full2", 64'(full[2]), 64'((i + 1) == 16));
        end
        check("fill_empty", 64'(empty), 64'(4'b1011));
        wr(2'd2, 32'hDEAD);
        check("ovf_flag", 64'(overflow), 64'(4'b0100));
        check("ovf_count2", 64'(cnt(2)), 64'(16));

        // Drain channel 2 back-to-back, then read it once more while empty.
        for (int i = 0; i < 16; i++) rd(2'd2, 32'h100 + 32'(i));
        check("drain_count2", 64'(cnt(2)), 64'(0));
        check("drain_empty2", 64'(empty[2]), 64'(1));
        drive(1'b0, '0, '0, 1'b1, 2'd2, '0, 1'b0, '0);
        check("udf_flag", 64'(underflow), 64'(4'b0100));
        check("udf_ovf_sticky", 64'(overflow[2]), 64'(1));
        idle(1);

        // Interleaved channels 0 and 1.
        wr(2'd0, 32'hA0); wr(2'd1, 32'hB0); wr(2'd0, 32'hA1); wr(2'd1, 32'hB1);
        check("ilv_count0", 64'(cnt(0)), 64'(2));
        check("ilv_count1", 64'(cnt(1)), 64'(2));
        rd(2'd1, 32'hB0);
        check("ilv_count0_after1", 64'(cnt(0)), 64'(2));
        check("ilv_count1_after1", 64'(cnt(1)), 64'(1));
        rd(2'd0, 32'hA0); rd(2'd1, 32'hB1); rd(2'd0, 32'hA1);
        check("ilv_empty", 64'(empty), 64'(4'hF));

        // Channel 3 at count 5, concurrent write+read for 40 cycles (wraps pointers).
        for (int i = 0; i < 5; i++) wr(2'd3, 32'h300 + 32'(i));
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 2'd3, 32'h305 + 32'(i), 1'b1, 2'd3, '0, 1'b1, 32'h300 + 32'(i));
            check("wr_rd_count3", 64'(cnt(3)), 64'(5));
        end
        for (int i = 40; i < 45; i++) rd(2'd3, 32'h300 + 32'(i));
        check("wr_rd_empty3", 64'(empty[3]), 64'(1));

        // Channel 1: overflow, partially drained to 8, then clear with a write to it.
        wr(2'd0, 32'hC0); wr(2'd0, 32'hC1);
        for (int i = 0; i < 16; i++) wr(2'd1, 32'h1A0 + 32'(i));
        wr(2'd1, 32'hBEEF);
        check("clr_pre_ovf1", 64'(overflow[1]), 64'(1));
        for (int i = 0; i < 8; i++) rd(2'd1, 32'h1A0 + 32'(i));
        check("clr_pre_count1", 64'(cnt(1)), 64'(8));
        drive(1'b1, 2'd1, 32'hBAD, 1'b0, '0, 4'b0010, 1'b0, '0);
        check("clr_count1", 64'(cnt(1)), 64'(0));
        check("clr_empty1", 64'(empty[1]), 64'(1));
        check("clr_ovf", 64'(overflow), 64'(4'b0100));
        check("clr_udf2_kept", 64'(underflow), 64'(4'b0100));
        check("clr_count0", 64'(cnt(0)), 64'(2));

        // Read of empty ch1 together with a write to it: read rejected, write lands.
        drive(1'b1, 2'd1, 32'h1B0, 1'b1, 2'd1, '0, 1'b0, '0);
        check("nofall_count1", 64'(cnt(1)), 64'(1));
        check("nofall_udf", 64'(underflow), 64'(4'b0110));
        rd(2'd1, 32'h1B0);
        rd(2'd0, 32'hC0);
        rd(2'd0, 32'hC1);

        // Read accepted, then clear of that channel on the next edge: data still returned.
        wr(2'd2, 32'h2C0);
        rd(2'd2, 32'h2C0);
        drive(1'b0, '0, '0, 1'b0, '0, 4'b0100, 1'b0, '0);
        check("rdclr_flags", 64'(overflow | underflow), 64'(4'b0010));
        idle(1);

        // Reset in the middle of traffic with a read in flight.
        wr(2'd0, 32'hE0); wr(2'd0, 32'hE1);
        re = 1'b1; rchannel = 2'd0;
        @(posedge clk);
        #1;
        re = 1'b0;
        resetn = 1'b0;
        #1;
        check_reset_state("midreset");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(3);
        check("post_reset_empty", 64'(empty), 64'(4'hF));
        check("post_reset_count", 64'(count), 64'(0));

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
